// File: rtl/coo_edge_addr_gen_if.sv
// Beat interface between the COO edge address generator and the row/col/value memories.
interface coo_edge_addr_gen_if #(
    parameter int ADDR_W = 6,
    parameter int LANES  = 2
);
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_base;
    logic [LANES-1:0]  lane_mask;
    logic              last;

    modport master (output addr_valid, addr_base, lane_mask, last, input addr_ready);
    modport slave  (input addr_valid, addr_base, lane_mask, last, output addr_ready);
endinterface

// File: rtl/coo_edge_addr_gen.sv
// Issues LANES consecutive COO edge indices per beat for a programmable edge count,
// with tail masking, last-beat flag, one-cycle done pulse and synchronous abort.
module coo_edge_addr_gen #(
    parameter int MAX_EDGES = 64,
    parameter int LANES     = 2,
    parameter int ADDR_W    = $clog2(MAX_EDGES),
    parameter int CNT_W     = $clog2(MAX_EDGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [CNT_W-1:0]      num_edges_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  done_o,
    coo_edge_addr_gen_if.master   addr_if
);
    // state  | meaning
    // S_IDLE | waiting for start
    // S_RUN  | issuing beats
    // S_DONE | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam int SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_EDGES);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [LANES-1:0]  mask_q, mask_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  n_clamp;
    logic [ADDR_W-1:0] base_adv;

    // Extended width keeps base+i and base+LANES from overflowing near MAX_EDGES.
    function automatic logic [LANES-1:0] mask_for(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0] n);
        mask_for = '0;
        for (int i = 0; i < LANES; i++) begin
            mask_for[i] = (SW'(b) + SW'(i)) < SW'(n);
        end
    endfunction

    function automatic logic last_for(input logic [ADDR_W-1:0] b,
                                      input logic [CNT_W-1:0] n);
        last_for = (SW'(b) + SW'(LANES)) >= SW'(n);
    endfunction

    assign n_clamp  = (num_edges_i > MAX_N) ? MAX_N : num_edges_i;
    assign base_adv = base_q + ADDR_W'(LANES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        base_d  = base_q;
        mask_d  = mask_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (clear_i) begin
            state_d = S_IDLE;
            base_d  = '0;
            mask_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        n_d    = n_clamp;
                        busy_d = 1'b1;
                        base_d = '0;
                        if (n_clamp == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            valid_d = 1'b1;
                            mask_d  = mask_for('0, n_clamp);
                            last_d  = last_for('0, n_clamp);
                        end
                    end
                end
                S_RUN: begin
                    if (valid_q && addr_if.addr_ready) begin
                        if (last_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            valid_d = 1'b0;
                            base_d  = '0;
                            mask_d  = '0;
                            last_d  = 1'b0;
                        end else begin
                            base_d = base_adv;
                            mask_d = mask_for(base_adv, n_q);
                            last_d = last_for(base_adv, n_q);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign addr_if.addr_valid = valid_q;
    assign addr_if.addr_base  = base_q;
    assign addr_if.lane_mask  = mask_q;
    assign addr_if.last       = last_q;
endmodule

// File: tb/tb_coo_edge_addr_gen.sv
// Directed bench for coo_edge_addr_gen with MAX_EDGES=64, LANES=2.
module tb_coo_edge_addr_gen;
    localparam int MAX_EDGES = 64;
    localparam int LANES     = 2;
    localparam int ADDR_W    = $clog2(MAX_EDGES);
    localparam int CNT_W     = $clog2(MAX_EDGES + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [CNT_W-1:0] num_edges_i;
    logic             clear_i;
    logic             busy_o;
    logic             done_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int acc_snap;

    coo_edge_addr_gen_if #(.ADDR_W(ADDR_W), .LANES(LANES)) aif ();

    coo_edge_addr_gen #(.MAX_EDGES(MAX_EDGES), .LANES(LANES)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .num_edges_i (num_edges_i),
        .clear_i     (clear_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .addr_if     (aif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (aif.addr_valid && aif.addr_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int b, input int m, input int l);
        chk({tag, "_valid"}, int'(aif.addr_valid), 1);
        chk({tag, "_base"},  int'(aif.addr_base), b);
        chk({tag, "_mask"},  int'(aif.lane_mask), m);
        chk({tag, "_last"},  int'(aif.last), l);
        chk({tag, "_busy"},  int'(busy_o), 1);
        chk({tag, "_done"},  int'(done_o), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, int'(aif.addr_valid), 0);
        chk({tag, "_base"},  int'(aif.addr_base), 0);
        chk({tag, "_mask"},  int'(aif.lane_mask), 0);
        chk({tag, "_last"},  int'(aif.last), 0);
        chk({tag, "_busy"},  int'(busy_o), 0);
        chk({tag, "_done"},  int'(done_o), 0);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, "_valid"}, int'(aif.addr_valid), 0);
        chk({tag, "_busy"},  int'(busy_o), 1);
        chk({tag, "_done"},  int'(done_o), 1);
    endtask

    task automatic do_start(input int n);
        start_i     = 1'b1;
        num_edges_i = CNT_W'(n);
        tick();
        start_i     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; num_edges_i = '0; clear_i = 1'b0;
        aif.addr_ready = 1'b1;
        tick(); tick();
        chk_idle("rst");
        reset = 1'b0;
        tick();

        // n=6: three full beats
        do_start(6);
        chk_beat("n6_b0", 0, 3, 0); tick();
        chk_beat("n6_b1", 2, 3, 0); tick();
        chk_beat("n6_b2", 4, 3, 1); tick();
        chk_done("n6_done"); tick();
        chk_idle("n6_idle");

        // n=5: tail lane masked on final beat
        do_start(5);
        chk_beat("n5_b0", 0, 3, 0); tick();
        chk_beat("n5_b1", 2, 3, 0); tick();
        chk_beat("n5_b2", 4, 1, 1); tick();
        chk_done("n5_done"); tick();
        chk_idle("n5_idle");

        // n=6 with backpressure at base 2
        acc_snap = acc_cnt;
        do_start(6);
        chk_beat("bp_b0", 0, 3, 0); tick();
        aif.addr_ready = 1'b0;
        chk_beat("bp_b1", 2, 3, 0); tick();
        chk_beat("bp_h1", 2, 3, 0); tick();
        chk_beat("bp_h2", 2, 3, 0); tick();
        chk_beat("bp_h3", 2, 3, 0);
        aif.addr_ready = 1'b1; tick();
        chk_beat("bp_b2", 4, 3, 1); tick();
        chk_done("bp_done"); tick();
        chk_idle("bp_idle");
        chk("bp_accepted", acc_cnt - acc_snap, 3);

        // n=0: straight to done
        do_start(0);
        chk_done("n0_done"); tick();
        chk_idle("n0_idle");

        // n=100 clamps to 64: 32 beats
        do_start(100);
        for (int k = 0; k < 32; k++) begin
            chk_beat($sformatf("clamp_b%0d", k), 2 * k, 3, (k == 31) ? 1 : 0);
            tick();
        end
        chk_done("clamp_done"); tick();
        chk_idle("clamp_idle");

        // clear at base 2 with a handshake pending
        do_start(6);
        chk_beat("clr_b0", 0, 3, 0); tick();
        chk_beat("clr_b1", 2, 3, 0);
        clear_i = 1'b1; tick();
        clear_i = 1'b0;
        chk_idle("clr_idle"); tick();
        chk_idle("clr_idle2");

        // clear beats start in the same cycle
        clear_i = 1'b1; start_i = 1'b1; num_edges_i = CNT_W'(6); tick();
        clear_i = 1'b0; start_i = 1'b0;
        chk_idle("clr_start");

        do_start(4);
        chk_beat("n4_b0", 0, 3, 0); tick();
        chk_beat("n4_b1", 2, 3, 1); tick();
        chk_done("n4_done"); tick();
        chk_idle("n4_idle");

        // start while busy is ignored
        do_start(6);
        chk_beat("ign_b0", 0, 3, 0);
        start_i = 1'b1; num_edges_i = CNT_W'(10); tick();
        start_i = 1'b0;
        chk_beat("ign_b1", 2, 3, 0); tick();
        chk_beat("ign_b2", 4, 3, 1); tick();
        chk_done("ign_done"); tick();
        chk_idle("ign_idle");

        // async reset at base 4
        do_start(8);
        tick(); tick();
        chk_beat("ar_b2", 4, 3, 0);
        reset = 1'b1; #1;
        chk_idle("ar_now");
        tick();
        reset = 1'b0; tick();
        chk_idle("ar_after");

        do_start(2);
        chk_beat("n2_b0", 0, 3, 1); tick();
        chk_done("n2_done"); tick();
        chk_idle("n2_idle");
        tick();

        chk("done_pulses", done_cnt, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/coo_edge_addr_gen.md
Name: coo_edge_addr_gen

Overview:
- Parametrised successor to the single-lane COO column counter used by the aggregation stage of the GCN datapath.
- Emits LANES consecutive COO edge indices per beat over a valid/ready interface, for a runtime-programmable edge count.
- Provides start/busy/done control, tail-lane masking, last-beat flag and synchronous abort.
- Sits between the layer controller and the COO row/col/value memories feeding the parallel aggregation lanes.

Parameters:
- MAX_EDGES, 64: largest edge count supported; COO memory depth.
- LANES, 2: edge indices issued per beat; must be 1..MAX_EDGES.
- ADDR_W, $clog2(MAX_EDGES): width of an edge index.
- CNT_W, $clog2(MAX_EDGES+1): width of the edge-count input.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a pass. Sampled only in IDLE.
- num_edges  in  CNT_W  edge count for this pass, latched on an accepted start.
- clear  in  1  synchronous abort; returns the block to IDLE.
- busy  out  1  high in RUN and DONE.
- addr_valid  out  1  beat valid.
- addr_ready  in  1  downstream accepts the beat.
- addr_base  out  ADDR_W  index of lane 0; lane i index = addr_base+i.
- lane_mask  out  LANES  bit i set iff addr_base+i < latched count.
- last  out  1  current beat is the final beat of the pass.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (async) values: all outputs 0, state IDLE, latched count 0.
- All outputs are registered. While addr_valid=1 and addr_ready=0, addr_base, lane_mask and last hold stable.
- States: IDLE, RUN, DONE.
- IDLE + start:
  - Latch n = min(num_edges, MAX_EDGES).
  - If n==0, go to DONE.
  - Otherwise go to RUN with addr_base=0 and addr_valid=1 on the next cycle (1-cycle start-to-first-beat latency).
- RUN, handshake (addr_valid & addr_ready):
  - If last=1, go to DONE with addr_valid=0.
  - Otherwise addr_base += LANES and lane_mask/last are recomputed for the new base.
  - Back-to-back handshakes sustain one beat per cycle.
- Tail lane masking: lane_mask = bits where base+i < n.
- last = (base + LANES >= n). Compute in CNT_W+1 bits so base+LANES never overflows.
- Tail example: n=5, LANES=2 gives final beat base=4, mask=01.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. done never asserts in any other state.
- start while busy is ignored and the latched count is unchanged.
- start with num_edges > MAX_EDGES is clamped to MAX_EDGES, with no error.
- clear (any state):
  - Next cycle IDLE; addr_valid, busy, last, lane_mask and addr_base are 0.
  - No done pulse.
  - clear has priority over start and over a handshake in the same cycle.
- Reset mid-pass: immediate return to IDLE with reset values. The next start begins from base 0.
- Address wrap: addr_base never exceeds n-1 and is re-zeroed on each new pass. No modular wrap within a pass.

Test Plan:
- LANES=2, MAX_EDGES=64, start with num_edges=6, addr_ready=1 -> beats base 0,2,4, each mask 11; last on base 4; done pulse the cycle after; busy low the cycle after done.
- num_edges=5, addr_ready=1 -> bases 0,2,4 with masks 11,11,01; last on the third beat; exactly one done.
- num_edges=6, addr_ready low for 3 cycles during base=2 -> base, mask and last held stable throughout; sequence otherwise identical to the first test; total 3 accepted beats.
- num_edges=0 -> no addr_valid; busy high for 1 cycle; done pulse 1 cycle after start. num_edges=100 -> clamped to 64, giving 32 beats with last on base 62.
- clear asserted during RUN at base=2 -> IDLE next cycle, all outputs 0, no done. A new start with num_edges=4 -> bases 0,2.
- start pulsed mid-pass with num_edges=10 -> ignored; the pass completes with the original count. Async reset at base=4 -> outputs 0 immediately, with no done.
